// File: rtl/ts_bus_pkg.sv
// Shared types and sizing helpers for the tristate bus arbiter.
package ts_bus_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'd1 << r) < 64'(v))) r = r + 1;
        return r;
    endfunction

    // Field width for an index/count covering v values, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/ts_bus_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above ptr_i, wrapping.
module ts_rr_arbiter
    import ts_bus_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0]                 req_i,
    input  logic [idx_width(NCH)-1:0]      ptr_i,
    output logic [NCH-1:0]                 pick_o,
    output logic [idx_width(NCH)-1:0]      idx_o,
    output logic                           any_o
);

    localparam int unsigned IW = idx_width(NCH);

    int unsigned cand;
    logic        found;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= NCH) cand = cand - NCH;
            if (!found && req_i[cand[IW-1:0]]) begin
                found                  = 1'b1;
                idx_o                  = cand[IW-1:0];
                pick_o[cand[IW-1:0]]   = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/ts_bus_arbiter.sv
// NCH-source round-robin owner of a shared tristate bus with burst limit and turnaround gap.
// Define TS_BUS_KEEPER_EN to hold the last driven value on dout instead of floating it.
module ts_bus_arbiter
    import ts_bus_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned NCH         = 4,
    parameter int unsigned MAX_BURST   = 8,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NCH-1:0]                req,
    input  logic [NCH*WIDTH-1:0]          din,
    output logic [NCH-1:0]                grant,
    output logic [idx_width(NCH)-1:0]     owner,
    output logic                          drive,
    output tri   [WIDTH-1:0]              dout
);

    localparam int unsigned OW = idx_width(NCH);
    localparam int unsigned BW = idx_width(MAX_BURST + 1);
    localparam int unsigned TW = 2;

    state_e          state_q, state_d;
    logic [NCH-1:0]  grant_q, grant_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            drive_q, drive_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [TW-1:0]   turn_q, turn_d;

    logic [OW-1:0]   next_ptr;
    logic [OW-1:0]   arb_ptr;
    logic [NCH-1:0]  arb_pick;
    logic [OW-1:0]   arb_idx;
    logic            arb_any;
    logic            arb_en;
    logic            rel_c;
    logic [WIDTH-1:0] bus_data;
    logic [WIDTH-1:0] din_arr [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_din
        assign din_arr[g] = din[g*WIDTH +: WIDTH];
    end

    // Releasing owner hands priority to its upper neighbour.
    assign next_ptr = (owner_q == OW'(NCH - 1)) ? '0 : owner_q + OW'(1);
    // Zero-gap handoff arbitrates in DRIVE against the post-release pointer.
    assign arb_ptr  = (state_q == DRIVE) ? next_ptr : ptr_q;

    ts_rr_arbiter #(
        .NCH    (NCH)
    ) u_rr (
        .req_i  (req),
        .ptr_i  (arb_ptr),
        .pick_o (arb_pick),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    assign rel_c = !req[owner_q] ||
                   ((MAX_BURST != 0) && (burst_q == BW'(MAX_BURST)));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        drive_d = drive_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        turn_d  = turn_q;
        arb_en  = 1'b0;
        case (state_q)
            IDLE: arb_en = 1'b1;
            DRIVE: begin
                if (rel_c) begin
                    grant_d = '0;
                    drive_d = 1'b0;
                    ptr_d   = next_ptr;
                    if (TURN_CYCLES != 0) begin
                        state_d = TURN;
                        turn_d  = TW'(1);
                    end else begin
                        state_d = IDLE;
                        arb_en  = 1'b1;
                    end
                end else if (MAX_BURST != 0) begin
                    burst_d = burst_q + BW'(1);
                end
            end
            TURN: begin
                if (turn_q == TW'(TURN_CYCLES)) begin
                    state_d = IDLE;
                    arb_en  = 1'b1;
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (arb_en && arb_any) begin
            state_d = DRIVE;
            grant_d = arb_pick;
            owner_d = arb_idx;
            drive_d = 1'b1;
            burst_d = BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            drive_q <= 1'b0;
            ptr_q   <= '0;
            burst_q <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            drive_q <= drive_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            turn_q  <= turn_d;
        end
    end

    assign bus_data = din_arr[owner_q];
    assign grant    = grant_q;
    assign owner    = owner_q;
    assign drive    = drive_q;

`ifdef TS_BUS_KEEPER_EN
    logic [WIDTH-1:0] keeper_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       keeper_q <= '0;
        else if (drive_q) keeper_q <= bus_data;
    end

    assign dout = drive_q ? bus_data : keeper_q;
`else
    assign dout = drive_q ? bus_data : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_ts_bus_arbiter.sv
// Directed scoreboard bench for ts_bus_arbiter (default build and TS_BUS_KEEPER_EN build).
module tb_ts_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_a, req_b;
    logic [63:0] din;
    logic [3:0]  grant_a, grant_b;
    logic [1:0]  owner_a, owner_b;
    logic        drive_a, drive_b;
    tri   [15:0] dout_a, dout_b;

    always #5 clk = ~clk;

    ts_bus_arbiter #(.WIDTH(16), .NCH(4), .MAX_BURST(8), .TURN_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req_a), .din(din),
        .grant(grant_a), .owner(owner_a), .drive(drive_a), .dout(dout_a)
    );

    ts_bus_arbiter #(.WIDTH(16), .NCH(4), .MAX_BURST(8), .TURN_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req_b), .din(din),
        .grant(grant_b), .owner(owner_b), .drive(drive_b), .dout(dout_b)
    );

    typedef struct {
        string       tag;
        logic [3:0]  grant;
        logic        drive;
        logic [1:0]  owner;
        logic [15:0] dout;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          sel   = 0;
    logic [15:0] kept [2];
    logic [15:0] src_data [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] idle_val(input int s);
`ifdef TS_BUS_KEEPER_EN
        return kept[s];
`else
        if (s < 0) return 16'h0000;
        return 16'hzzzz;
`endif
    endfunction

    task automatic compare_out();
        exp_t        e;
        logic [3:0]  og;
        logic        od;
        logic [1:0]  oo;
        logic [15:0] ov;
        e  = sb.pop_front();
        og = (sel != 0) ? grant_b : grant_a;
        od = (sel != 0) ? drive_b : drive_a;
        oo = (sel != 0) ? owner_b : owner_a;
        ov = (sel != 0) ? dout_b  : dout_a;
        chk({e.tag, "_grant"}, 32'(og), 32'(e.grant));
        chk({e.tag, "_drive"}, 32'(od), 32'(e.drive));
        chk({e.tag, "_dout"},  32'(ov), 32'(e.dout));
        chk({e.tag, "_onehot"}, 32'($onehot0(og)), 32'(1));
        chk({e.tag, "_drv_eq_or_grant"}, 32'(od), 32'(|og));
        if (e.drive) chk({e.tag, "_owner"}, 32'(oo), 32'(e.owner));
    endtask

    // Drive req for one cycle and queue the outputs expected after the next edge.
    task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] g);
        exp_t e;
        if (sel != 0) begin req_b = r; req_a = '0; end
        else          begin req_a = r; req_b = '0; end
        e.tag   = tag;
        e.grant = g;
        e.drive = |g;
        e.owner = '0;
        e.dout  = idle_val(sel);
        for (int i = 0; i < 4; i++) begin
            if (g[i[1:0]]) begin
                e.owner   = i[1:0];
                e.dout    = src_data[i];
                kept[sel] = src_data[i];
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic do_reset(input string tag);
        req_a   = '0;
        req_b   = '0;
        rst_n   = 1'b0;
        kept[0] = '0;
        kept[1] = '0;
        #1;
        chk({tag, "_grant"}, 32'(grant_a), 32'(0));
        chk({tag, "_drive"}, 32'(drive_a), 32'(0));
        chk({tag, "_dout"},  32'(dout_a),  32'(idle_val(0)));
        chk({tag, "_grant0"}, 32'(grant_b), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_owner"}, 32'(owner_a), 32'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5];
        order       = '{0, 1, 2, 3, 0};
        src_data[0] = 16'h0F0F;
        src_data[1] = 16'hA5A5;
        src_data[2] = 16'h5A5A;
        src_data[3] = 16'h1234;
        din = {src_data[3], src_data[2], src_data[1], src_data[0]};
        sel = 0;

        do_reset("rst");
        cyc("idle", 4'b0000, 4'b0000);
        cyc("idle", 4'b0000, 4'b0000);

        // Source 1 for three cycles, one turnaround cycle, then idle.
        repeat (3) cyc("s1", 4'b0010, 4'b0010);
        cyc("s1_turn", 4'b0000, 4'b0000);
        cyc("s1_idle", 4'b0000, 4'b0000);

        // Reset asserted mid-drive must float the bus before the next edge.
        cyc("pre_rst", 4'b0001, 4'b0001);
        #2;
        rst_n   = 1'b0;
        kept[0] = '0;
        #1;
        chk("async_rst_dout",  32'(dout_a),  32'(idle_val(0)));
        chk("async_rst_grant", 32'(grant_a), 32'(0));
        chk("async_rst_drive", 32'(drive_a), 32'(0));
        do_reset("rst2");

        // All four requesting: full bursts in round-robin order with one gap each.
        for (int k = 0; k < 5; k++) begin
            repeat (8) cyc("rr", 4'b1111, 4'(1 << order[k]));
            if (k < 4) cyc("rr_turn", 4'b1111, 4'b0000);
        end
        cyc("rr_end", 4'b0000, 4'b0000);

        // Sole continuous requester is regranted after each burst.
        do_reset("rst3");
        repeat (8) cyc("s2_b1", 4'b0100, 4'b0100);
        cyc("s2_t1", 4'b0100, 4'b0000);
        repeat (8) cyc("s2_b2", 4'b0100, 4'b0100);
        cyc("s2_t2", 4'b0100, 4'b0000);
        repeat (2) cyc("s2_b3", 4'b0100, 4'b0100);
        cyc("s2_end", 4'b0000, 4'b0000);

        // Source 3 then release: floats, or holds 1234 with the keeper.
        do_reset("rst4");
        repeat (2) cyc("s3", 4'b1000, 4'b1000);
        repeat (3) cyc("s3_hold", 4'b0000, 4'b0000);

        // Zero-gap instance: back-to-back handoff from source 0 to source 1.
        do_reset("rst5");
        sel = 1;
        repeat (2) cyc("tc0_s0", 4'b0011, 4'b0001);
        repeat (2) cyc("tc0_s1", 4'b0010, 4'b0010);
        cyc("tc0_end", 4'b0000, 4'b0000);
        sel = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ts_bus_arbiter.md
Name: ts_bus_arbiter

Overview:
- Parametrised successor of the single-source 16-bit tristate bus driver.
- NCH sources share one tristate data bus.
- Round-robin arbitration with registered grant, burst limit, and programmable turnaround gap between owners so two drivers never overlap.
- Sits between datapath sources (ALU, regfile, memory read port) and the shared internal data bus of the microprocessor.

Parameters:
- WIDTH, 16, bus data width in bits.
- NCH, 4, number of requesting sources (1..16).
- MAX_BURST, 8, max consecutive driven cycles per grant; 0 = unlimited.
- TURN_CYCLES, 1, undriven cycles inserted between owners (0..3).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NCH  per-source bus request, level-sensitive.
- din  in  NCH*WIDTH  source data, source i at bits [i*WIDTH +: WIDTH].
- grant  out  NCH  registered one-hot grant; all zero when nobody owns the bus.
- owner  out  max(1,clog2(NCH))  index of the current owner; valid only when drive=1.
- drive  out  1  registered; 1 while dout is driven.
- dout  out (tri)  WIDTH  equals din[owner] combinationally when drive=1, else all Z.

Behaviour:
- Reset (async, rst_n=0), applied immediately regardless of state:
  - state=IDLE, grant=0, drive=0, owner=0, dout=Z.
  - rr pointer=0 (source 0 has first priority), burst count=0, turn count=0.
- States: IDLE, DRIVE, TURN.
- Arbitration picks the first asserted req searching upward from the rr pointer, wrapping modulo NCH.
- IDLE:
  - If any req=1 at edge k: grant/owner/drive set at edge k, state=DRIVE, burst count=1.
  - Latency is one cycle from req to dout valid.
- DRIVE:
  - dout passes din[owner] with no register stage.
  - Release at an edge where req[owner]=0, or where burst count==MAX_BURST (MAX_BURST≠0).
  - The cycle in which req drops is still driven. A source wanting N cycles holds req for N cycles.
  - On release: grant=0, drive=0, rr pointer=owner+1 mod NCH.
  - If TURN_CYCLES>0: state=TURN, turn count=1.
  - If TURN_CYCLES==0: arbitrate at the same edge for back-to-back handoff with no Z cycle. A new owner may be granted, including the same source if it is the only requester.
  - Otherwise increment burst count.
- TURN:
  - dout=Z and grant=0.
  - When turn count==TURN_CYCLES, arbitrate as in IDLE (grant → DRIVE, none → IDLE). Otherwise increment turn count.
  - Requests never shorten the gap.
- Exactly TURN_CYCLES undriven cycles occur between consecutive owners.
- A sole continuous requester is regranted after its MAX_BURST expires, following the TURN gap.
- req changes of non-owners during DRIVE/TURN have no effect until the next arbitration point.
- NCH=1: owner is a constant 0, and the burst/turn rules still apply.
- grant is one-hot or zero at all times. drive == |grant.

Optional Feature:
- Macro: TS_BUS_KEEPER_EN.
- Defined:
  - A WIDTH-bit keeper register captures dout on every driven cycle; reset value 0.
  - When drive=0, dout outputs the keeper value instead of Z, so the bus is never floating.
  - The drive output still reports 0 in that case.
- Undefined: dout is all Z when drive=0, and there is no keeper register.

Decomposition:
- Package ts_bus_pkg:
  - State encoding constants IDLE/DRIVE/TURN.
  - Default WIDTH=16.
  - clog2 function for sizing the owner and count fields.
- Sub-module ts_rr_arbiter:
  - Combinational NCH-wide round-robin picker.
  - Inputs: req, pointer. Outputs: one-hot pick, index, any.
- The parent owns the pointer register, FSM, counters, tristate assign and optional keeper.

Test Plan (all with NCH=4, WIDTH=16, MAX_BURST=8, TURN_CYCLES=1 unless stated):
- Reset, no req → dout=Z, grant=0, drive=0. Assert rst_n=0 while driving → dout=Z immediately, before the next clk edge.
- req=0010, din[1]=16'hA5A5, held 3 cycles → grant=0010 the cycle after req. dout=A5A5 for exactly 3 cycles, then 1 Z cycle.
- req=1111 held continuously → owners 0,1,2,3,0 in order. Each owner drives 8 cycles with 1 Z cycle between; grant never has 2 bits set.
- req=0100 held 20 cycles → source 2 drives 8, Z 1, drives 8, Z 1, drives 2.
- TURN_CYCLES=0, req=0011 each held 2 cycles → source 0 drives 2 cycles, immediately followed by source 1 for 2 cycles, with no Z cycle.
- TS_BUS_KEEPER_EN defined: source 3 drives 16'h1234, then releases → dout stays 16'h1234 while drive=0.
